unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
// - Shares one single-ported, variable-latency memory between the pipeline's IF fetch port and MEM-stage load/store port.
// - Sits between the pipe CPU and the unified memory and replaces the separate instruction and data memories.
// - Serialises accesses, captures read data, and drives a global stall so every pipe register holds while an access is outstanding.
// PARAMETERS
// - AW, 32: address width (byte address, word aligned).
// - DW, 32: data width.
// - TIMEOUT_CYC, 255: maximum BUSY cycles before an access is aborted; must be >= 1.
// PORTS
// - clk_i        in   1   clock; all state updates on the rising edge.
// - rst_i        in   1   asynchronous reset, active-low.
// - if_req_i     in   1   fetch request; held until if_ready_o.
// - if_addr_i    in   AW  fetch address (PC).
// - if_rdata_o   out  DW  fetched instruction; valid only while if_ready_o=1.
// - if_ready_o   out  1   1-cycle completion pulse for the fetch.
// - dm_read_i    in   1   load request; held until dm_ready_o.
// - dm_write_i   in   1   store request; held until dm_ready_o.
// - dm_addr_i    in   AW  load/store address (ALU result).
// - dm_wdata_i   in   DW  store data.
// - dm_rdata_o   out  DW  load data; valid only while dm_ready_o=1.
// - dm_ready_o   out  1   1-cycle completion pulse for the load/store.
// - mem_req_o    out  1   memory request; held until mem_ack_i.
// - mem_we_o     out  1   1 = write, 0 = read.
// - mem_addr_o   out  AW  registered memory address.
// - mem_wdata_o  out  DW  registered write data.
// - mem_rdata_i  in   DW  read data; valid with mem_ack_i.
// - mem_ack_i    in   1   memory completion; ignored unless mem_req_o=1.
// - stall_o      out  1   freeze all pipe registers and the PC.
// - timeout_o    out  1   sticky error flag; cleared only by reset.
// BEHAVIOUR
// - Reset (async, rst_i=0):
//   - State goes to IDLE; rr_last=IF.
//   - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ready pulses, rdata outputs, timeout_o.
//   - An in-flight memory access is abandoned; a late mem_ack_i after reset is ignored.
// - States: IDLE -> BUSY -> DONE -> IDLE. An access in progress is also left for IDLE by timeout abort.
// - IDLE:
//   - Arbitrate among pending requests: dm_pend = dm_read_i | dm_write_i; if_req_i.
//   - If only one requester is pending, grant it.
//   - If both are pending, round-robin: grant the one not equal to rr_last (first contention after reset grants DM).
//   - On grant: register addr, wdata and we (we = dm_write_i; write wins if dm_read_i and dm_write_i are both 1). Set rr_last; go to BUSY.
// - BUSY:
//   - mem_req_o=1 with registered fields, stable until ack.
//   - On mem_ack_i: latch mem_rdata_i (reads only); go to DONE.
//   - Wait counter increments each BUSY cycle. When it reaches TIMEOUT_CYC without ack: set timeout_o, drop mem_req_o, go to IDLE. No ready pulse; the requester keeps stalling.
// - DONE:
//   - Pulse ready for the granted port only, for exactly 1 cycle, with rdata_o valid.
//   - Return to IDLE without re-arbitrating, because the requester's inputs are still asserted this cycle.
// - Latency: grant in cycle 0 (IDLE), mem_req_o from cycle 1, ack at cycle k>=1, ready at cycle k+1. Minimum 3 cycles per access.
// - The non-selected rdata_o is 0. A store's dm_rdata_o is 0.
// - stall_o (combinational) = (if_req_i & ~if_ready_o) | (dm_pend & ~dm_ready_o).
//   - Stall deasserts only in a cycle where every pending request is being completed.
//   - Because IF and DM complete in separate DONE cycles, contention implies at least one extra stall cycle.
// - Zero requests: stays in IDLE, mem_req_o=0, stall_o=0.
// - Requests must not change while pending: addr/data are captured at grant, and later changes are not seen.
// STRUCTURE
// - Shared include mem_arb_defs.vh holds:
//   - State encodings: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   - Grant IDs: GNT_IF=1'b0, GNT_DM=1'b1.
// - Sub-module wait_timer (counter with clear, enable, terminal-count output; width $clog2(TIMEOUT_CYC+1)).
// - The rest is a single FSM plus capture registers.
// TESTING
// - Lone fetch, addr 0x10, memory acks 1 cycle after req -> if_ready_o at cycle 3; if_rdata_o=mem word; stall_o=1 for cycles 0-2, 0 in cycle 3.
// - if_req_i and dm_read_i both high from reset -> DM served first, then IF; mem_addr_o sequence DM addr, then IF addr; exactly one ready pulse each.
// - Store 0xDEADBEEF to 0x40, then load 0x40 -> mem_we_o=1 then 0; dm_rdata_o=0xDEADBEEF; dm_rdata_o=0 on the store's ready cycle.
// - Memory ack delayed 7 cycles -> mem_req_o, mem_addr_o and mem_we_o stable all 7 cycles; ready at ack+1; no duplicate issue.
// - TIMEOUT_CYC=4, no ack -> mem_req_o drops after 4 BUSY cycles; timeout_o=1 stays set; no ready pulse; stall_o remains 1.
// - rst_i low during BUSY, then ack arrives -> all outputs 0 immediately; the late ack produces no ready pulse; the next request is served normally.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings and grant selection for the unified memory arbiter.
// Encodings match the legacy mem_arb_defs.vh values so traces stay comparable.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_e;

   // Under contention, the port that did not win last time gets the grant.
   function automatic gnt_e pick_grant(input logic if_pend, input logic dm_pend,
                                       input gnt_e rr_last);
      if (if_pend && dm_pend) begin
         if (rr_last == GNT_IF) return GNT_DM;
         return GNT_IF;
      end
      if (dm_pend) return GNT_DM;
      return GNT_IF;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_wait_timer.sv
// BUSY-cycle counter: cleared outside BUSY, counts while enabled, flags the
// cycle in which the LIMIT-th wait cycle elapses without completion.
module unified_mem_arbiter_wait_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_reg;

   assign tc = en && (count_reg == CW'(LIMIT - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + CW'(1);
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto one variable-latency
// memory port, capturing read data and stalling the pipe while access is owed.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_ready_o,
   input  logic          dm_read_i,
   input  logic          dm_write_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_ready_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ack_i,
   output logic          stall_o,
   output logic          timeout_o
);

   arb_state_e    state_reg;
   gnt_e          gnt_reg;
   gnt_e          rr_last_reg;
   gnt_e          gnt_next;
   logic          dm_pend;
   logic          mem_req_reg;
   logic          mem_we_reg;
   logic [AW-1:0] mem_addr_reg;
   logic [DW-1:0] mem_wdata_reg;
   logic [DW-1:0] if_rdata_reg;
   logic [DW-1:0] dm_rdata_reg;
   logic          if_ready_reg;
   logic          dm_ready_reg;
   logic          timeout_reg;
   logic          timer_clr;
   logic          timer_en;
   logic          timer_tc;

   assign dm_pend = dm_read_i | dm_write_i;

   always_comb begin
      gnt_next = pick_grant(if_req_i, dm_pend, rr_last_reg);
   end

   assign timer_clr = (state_reg != ST_BUSY);
   assign timer_en  = (state_reg == ST_BUSY) && !mem_ack_i;

   unified_mem_arbiter_wait_timer #(
      .LIMIT (TIMEOUT_CYC)
   ) u_wait_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (timer_clr),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg     <= ST_IDLE;
         gnt_reg       <= GNT_IF;
         rr_last_reg   <= GNT_IF;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         if_rdata_reg  <= '0;
         dm_rdata_reg  <= '0;
         if_ready_reg  <= 1'b0;
         dm_ready_reg  <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (if_req_i || dm_pend) begin
                  gnt_reg     <= gnt_next;
                  rr_last_reg <= gnt_next;
                  mem_req_reg <= 1'b1;
                  state_reg   <= ST_BUSY;
                  if (gnt_next == GNT_DM) begin
                     mem_addr_reg  <= dm_addr_i;
                     mem_we_reg    <= dm_write_i;
                     mem_wdata_reg <= dm_write_i ? dm_wdata_i : '0;
                  end else begin
                     mem_addr_reg  <= if_addr_i;
                     mem_we_reg    <= 1'b0;
                     mem_wdata_reg <= '0;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ack_i) begin
                  mem_req_reg <= 1'b0;
                  state_reg   <= ST_DONE;
                  if (gnt_reg == GNT_IF) begin
                     if_ready_reg <= 1'b1;
                     if_rdata_reg <= mem_rdata_i;
                  end else begin
                     dm_ready_reg <= 1'b1;
                     if (!mem_we_reg) dm_rdata_reg <= mem_rdata_i;
                  end
               end else if (timer_tc) begin
                  // Abort without a ready pulse; the requester stays stalled.
                  mem_req_reg <= 1'b0;
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_IDLE;
               end
            end
            ST_DONE: begin
               // Requests are still asserted this cycle, so no re-arbitration.
               if_ready_reg <= 1'b0;
               dm_ready_reg <= 1'b0;
               if_rdata_reg <= '0;
               dm_rdata_reg <= '0;
               state_reg    <= ST_IDLE;
            end
            default: begin
               mem_req_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_reg;
   assign mem_we_o    = mem_we_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_wdata_o = mem_wdata_reg;
   assign if_rdata_o  = if_rdata_reg;
   assign dm_rdata_o  = dm_rdata_reg;
   assign if_ready_o  = if_ready_reg;
   assign dm_ready_o  = dm_ready_reg;
   assign timeout_o   = timeout_reg;
   assign stall_o     = (if_req_i & ~if_ready_reg) | (dm_pend & ~dm_ready_reg);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter with a memory
// responder and a cycle-window reference model of each access.
module tb_unified_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 12;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_rdata_o;
   logic          if_ready_o;
   logic          dm_read_i;
   logic          dm_write_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic [DW-1:0] dm_rdata_o;
   logic          dm_ready_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_ack_i;
   logic          stall_o;
   logic          timeout_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] phys [64];
   logic [31:0] gold [64];
   logic        mem_init;
   logic        ack_en;
   logic        force_ack;
   int          lat;
   int          req_age;
   bit          rr_dm;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
      .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .stall_o(stall_o), .timeout_o(timeout_o)
   );

   // Memory: acks in the lat-th cycle of a request; lat counts from 1.
   assign mem_ack_i   = force_ack | (ack_en & mem_req_o & (req_age == lat - 1));
   assign mem_rdata_i = phys[mem_addr_o[7:2]];

   always @(posedge clk) begin
      if (!mem_req_o || mem_ack_i) req_age <= 0;
      else                         req_age <= req_age + 1;
      if (mem_init) begin
         for (int i = 0; i < 64; i++) phys[i] <= gold[i];
      end else if (mem_req_o && mem_ack_i && mem_we_o) begin
         phys[mem_addr_o[7:2]] <= mem_wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      if_req_i = 1'b0; if_addr_i = '0;
      dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req_o, 0);
      chk({tag, "_mem_we"}, mem_we_o, 0);
      chk({tag, "_mem_addr"}, mem_addr_o, 0);
      chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
      chk({tag, "_if_ready"}, if_ready_o, 0);
      chk({tag, "_dm_ready"}, dm_ready_o, 0);
      chk({tag, "_if_rdata"}, if_rdata_o, 0);
      chk({tag, "_dm_rdata"}, dm_rdata_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
   endtask

   // One fetch and/or one load/store issued together; dm_mode 0=read 1=write 2=both.
   task automatic transact(input bit do_if, input logic [31:0] ia, input bit do_dm,
                           input int dm_mode, input logic [31:0] da, input logic [31:0] wd,
                           input int l);
      bit dm_first, dm_wr, if_done, dm_done, if_drv, dm_drv, finished, exp_req, in_if, in_dm;
      int g_if, g_dm, if_rdy, dm_rdy;
      logic [31:0] if_exp, dm_exp;
      lat = l; ack_en = 1'b1;
      dm_wr    = do_dm && (dm_mode != 0);
      dm_first = do_dm && (!do_if || !rr_dm);
      g_if = -100; g_dm = -100; if_exp = '0; dm_exp = '0;
      if (do_if) g_if = dm_first ? l + 2 : 0;
      if (do_dm) g_dm = dm_first ? 0 : l + 2;
      if_rdy = do_if ? g_if + l + 1 : -100;
      dm_rdy = do_dm ? g_dm + l + 1 : -100;
      if (do_if && !dm_first) if_exp = gold[ia[7:2]];
      if (do_dm) begin
         if (dm_wr) begin gold[da[7:2]] = wd; dm_exp = '0; end
         else dm_exp = gold[da[7:2]];
      end
      if (do_if && dm_first) if_exp = gold[ia[7:2]];
      if (do_if || do_dm) rr_dm = do_if && do_dm ? !dm_first : do_dm;
      $display("txn if=%0b ia=%h dm=%0b mode=%0d da=%h wd=%h lat=%0d dm_first=%0b",
               do_if, ia, do_dm, dm_mode, da, wd, l, dm_first);
      if_done = !do_if; dm_done = !do_dm; finished = 1'b0;
      for (int c = 0; c < 4 * l + 20; c++) begin
         @(posedge clk); #1;
         if_drv = !if_done; dm_drv = !dm_done;
         if_req_i = if_drv; if_addr_i = ia;
         dm_read_i = dm_drv && (dm_mode != 1); dm_write_i = dm_drv && (dm_mode != 0);
         dm_addr_i = da; dm_wdata_i = wd;
         #1;
         in_if = (c > g_if) && (c <= g_if + l);
         in_dm = (c > g_dm) && (c <= g_dm + l);
         exp_req = in_if || in_dm;
         chk($sformatf("stall_c%0d", c), stall_o, (if_drv && c != if_rdy) || (dm_drv && c != dm_rdy));
         chk($sformatf("mem_req_c%0d", c), mem_req_o, exp_req);
         chk($sformatf("if_ready_c%0d", c), if_ready_o, c == if_rdy);
         chk($sformatf("dm_ready_c%0d", c), dm_ready_o, c == dm_rdy);
         chk($sformatf("if_rdata_c%0d", c), if_rdata_o, (c == if_rdy) ? if_exp : 32'h0);
         chk($sformatf("dm_rdata_c%0d", c), dm_rdata_o, (c == dm_rdy) ? dm_exp : 32'h0);
         if (in_if) begin
            chk($sformatf("if_addr_c%0d", c), mem_addr_o, ia);
            chk($sformatf("if_we_c%0d", c), mem_we_o, 0);
         end
         if (in_dm) begin
            chk($sformatf("dm_addr_c%0d", c), mem_addr_o, da);
            chk($sformatf("dm_we_c%0d", c), mem_we_o, dm_wr);
            if (dm_wr) chk($sformatf("dm_wdata_c%0d", c), mem_wdata_o, wd);
         end
         if (!if_drv && !dm_drv) begin finished = 1'b1; break; end
         if (if_ready_o) if_done = 1'b1;
         if (dm_ready_o) dm_done = 1'b1;
      end
      chk("txn_completed", finished, 1);
      drive_idle();
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      drive_idle();
      #1;
      chk_all_zero("reset");
      chk("reset_stall", stall_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_i = 1'b1;
      rr_dm = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      int sel;
      rst_i = 1'b0; force_ack = 1'b0; ack_en = 1'b0; lat = 1; rr_dm = 1'b0;
      drive_idle();
      for (int i = 0; i < 64; i++) begin
         v = $urandom; gold[i] = v;
      end
      mem_init = 1'b1;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      do_reset();

      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         chk("idle_mem_req", mem_req_o, 0);
         chk("idle_stall", stall_o, 0);
      end

      // Contention straight out of reset: DM first, then IF.
      transact(1, 32'h20, 1, 0, 32'h30, 32'h0, 1);
      // Lone fetch, ack one cycle after request: ready at cycle 3.
      transact(1, 32'h10, 0, 0, 32'h0, 32'h0, 2);
      // Store then load the same word.
      transact(0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 1);
      transact(0, 32'h0, 1, 0, 32'h40, 32'h0, 3);
      // Long memory latency.
      transact(0, 32'h0, 1, 0, 32'h50, 32'h0, 8);
      // Read+write together behaves as a write.
      transact(1, 32'h44, 1, 2, 32'h44, 32'h12345678, 2);

      for (int t = 0; t < 30; t++) begin
         sel = $urandom_range(1, 3);
         transact(sel[0], {24'h0, 6'($urandom), 2'b00}, sel[1], $urandom_range(0, 2),
                  {24'h0, 6'($urandom), 2'b00}, $urandom, $urandom_range(1, 8));
      end

      // Timeout: no ack ever arrives for a fetch.
      ack_en = 1'b0;
      $display("txn timeout fetch addr=00000014");
      for (int c = 0; c <= TO + 6; c++) begin
         @(posedge clk); #1;
         if_req_i = 1'b1; if_addr_i = 32'h14;
         #1;
         chk($sformatf("to_mem_req_c%0d", c), mem_req_o, (c >= 1 && c <= TO) || (c >= TO + 2));
         chk($sformatf("to_timeout_c%0d", c), timeout_o, c >= TO + 1);
         chk($sformatf("to_if_ready_c%0d", c), if_ready_o, 0);
         chk($sformatf("to_stall_c%0d", c), stall_o, 1);
      end
      do_reset();

      // Reset during BUSY, then a late ack.
      $display("txn reset during busy addr=00000048");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         dm_read_i = 1'b1; dm_addr_i = 32'h48;
      end
      #1 chk("rb_busy_mem_req", mem_req_o, 1);
      do_reset();
      @(posedge clk); #1 force_ack = 1'b1;
      #1;
      chk("late_ack_mem_req", mem_req_o, 0);
      @(posedge clk); #1 force_ack = 1'b0;
      #1;
      chk("late_ack_dm_ready", dm_ready_o, 0);
      chk("late_ack_if_ready", if_ready_o, 0);
      chk("late_ack_mem_req2", mem_req_o, 0);
      transact(1, 32'h4C, 1, 0, 32'h48, 32'h0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
